// File: rtl/sam_vdg_counter.sv
// SAM video address counter: generates the VDG fetch address from da0_en, hs_n and fs_n
// with per-mode horizontal/vertical repeat dividers and memory-size masking.
module sam_vdg_counter #(
  parameter int ALPHA_YDIV = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        da0_en,
  input  logic        hs_n,
  input  logic        fs_n,
  input  logic [2:0]  vmode,
  input  logic [6:0]  disp_offset,
  input  logic [1:0]  mem_size,
  output logic [15:0] vaddr,
  output logic        frame_start,
  output logic        row_adv
);

  localparam int YW = (ALPHA_YDIV > 3) ? $clog2(ALPHA_YDIV) : 2;

  logic [3:0]    r_low;
  logic [11:0]   r_up;
  logic [15:0]   r_rowStart;
  logic [1:0]    r_xDiv;
  logic [YW-1:0] r_yDiv;
  logic [2:0]    r_mode;
  logic          r_hsPrev;
  logic          r_fsPrev;
  logic          r_hsArmed;
  logic          r_fsArmed;

  logic          w_hsFall;
  logic          w_fsFall;
  logic [1:0]    w_xLast;
  logic [YW-1:0] w_yLast;
  logic [3:0]    w_lowNext;
  logic [11:0]   w_upNext;
  logic [15:0]   w_rowNext;
  logic [1:0]    w_xNext;
  logic [YW-1:0] w_yNext;
  logic [2:0]    w_modeNext;
  logic          w_frameNext;
  logic          w_rowAdvNext;
  logic [15:0]   w_addrNext;
  logic [15:0]   w_vaddrNext;

  // Armed flops keep a sync that is already low at reset release from looking like an edge.
  assign w_hsFall = r_hsArmed & r_hsPrev & ~hs_n;
  assign w_fsFall = r_fsArmed & r_fsPrev & ~fs_n;

  always_comb begin
    w_xLast = 2'd0;
    w_yLast = '0;
    case (r_mode)
      3'b000:  w_yLast = YW'(ALPHA_YDIV - 1);
      3'b001:  w_xLast = 2'd2;
      3'b010:  w_yLast = YW'(2);
      3'b011:  w_xLast = 2'd1;
      3'b100:  w_yLast = YW'(1);
      default: ;
    endcase
  end

  always_comb begin
    w_lowNext    = r_low;
    w_upNext     = r_up;
    w_rowNext    = r_rowStart;
    w_xNext      = r_xDiv;
    w_yNext      = r_yDiv;
    w_modeNext   = r_mode;
    w_frameNext  = 1'b0;
    w_rowAdvNext = 1'b0;
    if (w_fsFall) begin
      w_upNext    = {disp_offset, 5'd0};
      w_lowNext   = 4'd0;
      w_rowNext   = {disp_offset, 9'd0};
      w_xNext     = 2'd0;
      w_yNext     = '0;
      w_modeNext  = vmode;
      w_frameNext = 1'b1;
    end else if (w_hsFall) begin
      w_xNext = 2'd0;
      if (r_yDiv == w_yLast) begin
        w_yNext      = '0;
        w_rowNext    = {r_up, r_low};
        w_rowAdvNext = 1'b1;
      end else begin
        w_yNext               = r_yDiv + YW'(1);
        {w_upNext, w_lowNext} = r_rowStart;
      end
    end else if (da0_en) begin
      w_lowNext = r_low + 4'd1;
      if (r_low == 4'hF) begin
        if (r_xDiv == w_xLast) begin
          w_xNext  = 2'd0;
          w_upNext = r_up + 12'd1;
        end else begin
          w_xNext = r_xDiv + 2'd1;
        end
      end
    end
  end

  assign w_addrNext = {w_upNext, w_lowNext};

  // Smaller memories alias the upper address lines on the output only.
  always_comb begin
    w_vaddrNext = w_addrNext;
    case (mem_size)
      2'b00:   w_vaddrNext[15:12] = 4'h0;
      2'b01:   w_vaddrNext[15:14] = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_low       <= 4'd0;
      r_up        <= 12'd0;
      r_rowStart  <= 16'd0;
      r_xDiv      <= 2'd0;
      r_yDiv      <= '0;
      r_mode      <= 3'b000;
      r_hsPrev    <= 1'b1;
      r_fsPrev    <= 1'b1;
      r_hsArmed   <= 1'b0;
      r_fsArmed   <= 1'b0;
      vaddr       <= 16'h0000;
      frame_start <= 1'b0;
      row_adv     <= 1'b0;
    end else begin
      r_low       <= w_lowNext;
      r_up        <= w_upNext;
      r_rowStart  <= w_rowNext;
      r_xDiv      <= w_xNext;
      r_yDiv      <= w_yNext;
      r_mode      <= w_modeNext;
      r_hsPrev    <= hs_n;
      r_fsPrev    <= fs_n;
      r_hsArmed   <= r_hsArmed | hs_n;
      r_fsArmed   <= r_fsArmed | fs_n;
      vaddr       <= w_vaddrNext;
      frame_start <= w_frameNext;
      row_adv     <= w_rowAdvNext;
    end
  end

endmodule
